// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed hex display scanner with a double-buffered load port.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always lit).
module seg_scan_driver #(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [15:0] load_value,
    output logic        load_ready,
    output logic [3:0]  digit_data,
    output logic [1:0]  digit_idx,
    output logic [3:0]  anode_n,
    output logic        frame_tick
);

    localparam int CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

    typedef enum logic {
        S_BLANK,
        S_ON
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      disp;
    logic [15:0]      shadow;
    logic             pending;

    logic             blank_done;
    logic             on_done;
    logic             load_fire;
    logic             commit;
    logic [1:0]       idx_nxt;
    logic [15:0]      disp_nxt;
    logic             digit_lit;

    function automatic logic [3:0] nibble(input logic [15:0] value, input logic [1:0] idx);
        logic [3:0] n;
        case (idx)
            2'd0:    n = value[3:0];
            2'd1:    n = value[7:4];
            2'd2:    n = value[11:8];
            default: n = value[15:12];
        endcase
        return n;
    endfunction

    assign blank_done = (state == S_BLANK) && (cnt == BLANK_LAST);
    assign on_done    = (state == S_ON)    && (cnt == DIV_LAST);
    assign frame_tick = on_done && (digit_idx == 2'd3);
    assign load_ready = !pending;
    assign load_fire  = load_valid && load_ready;
    // A load accepted in the frame_tick cycle has pending=0 here, so it waits a full frame.
    assign commit     = frame_tick && pending;
    assign idx_nxt    = digit_idx + 2'd1;
    assign disp_nxt   = commit ? shadow : disp;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            state <= S_BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_BLANK: if (blank_done) state_nxt = S_ON;
            S_ON:    if (on_done)    state_nxt = S_BLANK;
            default: state_nxt = S_BLANK;
        endcase
    end

    // Slot counter, scan index and display buffers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            digit_idx  <= 2'd0;
            digit_data <= 4'h0;
            disp       <= 16'h0000;
            shadow     <= 16'h0000;
            pending    <= 1'b0;
        end else begin
            cnt <= (blank_done || on_done) ? '0 : cnt + 1'b1;

            if (on_done) begin
                digit_idx  <= idx_nxt;
                digit_data <= nibble(disp_nxt, idx_nxt);
            end

            disp <= disp_nxt;

            if (load_fire) begin
                shadow  <= load_value;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        digit_lit = 1'b1;
        case (digit_idx)
            2'd1:    digit_lit = |disp[15:4];
            2'd2:    digit_lit = |disp[15:8];
            2'd3:    digit_lit = |disp[15:12];
            default: digit_lit = 1'b1;
        endcase
    end
`else
    assign digit_lit = 1'b1;
`endif

    // Output decode: at most one anode low, only during the ON window
    always_comb begin
        anode_n = 4'b1111;
        if (state == S_ON && digit_lit) begin
            anode_n[digit_idx] = 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with DIV=4, BLANK=2 (24-cycle frame).
// Expected digits are queued per frame from a bench-side display model and popped per slot.
module tb_seg_scan_driver;

    localparam int DIV   = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DIV + BLANK;
    localparam int FRAME = 4 * SLOT;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [15:0] load_value;
    logic        load_ready;
    logic [3:0]  digit_data;
    logic [1:0]  digit_idx;
    logic [3:0]  anode_n;
    logic        frame_tick;

    seg_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .digit_data (digit_data),
        .digit_idx  (digit_idx),
        .anode_n    (anode_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic       lit;
    } slot_t;

    slot_t       exp_q[$];
    int          tests_run;
    int          tests_failed;
    logic        exp_pending;
    logic [15:0] exp_disp;
    logic [15:0] exp_shadow;

    task automatic model_reset();
        exp_pending = 1'b0;
        exp_disp    = 16'h0000;
        exp_shadow  = 16'h0000;
        exp_q.delete();
    endtask

    task automatic push_frame();
        slot_t s;
        for (int k = 0; k < 4; k++) begin
            s.data = exp_disp[4*k +: 4];
            s.lit  = 1'b1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (k > 0 && (exp_disp >> (4 * k)) == 16'h0000) s.lit = 1'b0;
`endif
            exp_q.push_back(s);
        end
    endtask

    // Runs one full frame starting at its first cycle, optionally offering loads at two positions.
    task automatic run_frame(input string name, input int lpos1, input logic [15:0] lval1,
                             input int lpos2, input logic [15:0] lval2);
        int         slot;
        int         w;
        logic [3:0] exp_an;
        logic       accept;
        logic       commit;
        slot_t      e;
        push_frame();
        for (int p = 0; p < FRAME; p++) begin
            slot = p / SLOT;
            w    = p % SLOT;
            e    = exp_q[0];
            exp_an = 4'b1111;
            if (w >= BLANK && e.lit) exp_an[slot] = 1'b0;

            tests_run++;
            if (anode_n !== exp_an) begin
                tests_failed++;
                $display("FAIL %s anode_n p=%0d: got %b expected %b", name, p, anode_n, exp_an);
            end
            tests_run++;
            if (digit_idx !== 2'(slot)) begin
                tests_failed++;
                $display("FAIL %s digit_idx p=%0d: got %0d expected %0d", name, p, digit_idx, slot);
            end
            tests_run++;
            if (digit_data !== e.data) begin
                tests_failed++;
                $display("FAIL %s digit_data p=%0d: got %h expected %h", name, p, digit_data, e.data);
            end
            tests_run++;
            if (frame_tick !== (p == FRAME - 1)) begin
                tests_failed++;
                $display("FAIL %s frame_tick p=%0d: got %b expected %b", name, p, frame_tick, p == FRAME - 1);
            end
            tests_run++;
            if (load_ready !== !exp_pending) begin
                tests_failed++;
                $display("FAIL %s load_ready p=%0d: got %b expected %b", name, p, load_ready, !exp_pending);
            end
            if (w == SLOT - 1) void'(exp_q.pop_front());

            load_valid = (p == lpos1) || (p == lpos2);
            load_value = (p == lpos1) ? lval1 : ((p == lpos2) ? lval2 : 16'h0000);
            commit = (p == FRAME - 1) && exp_pending;
            accept = load_valid && !exp_pending;
            if (commit) begin
                exp_disp    = exp_shadow;
                exp_pending = 1'b0;
            end
            if (accept) begin
                exp_shadow  = load_value;
                exp_pending = 1'b1;
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_value = 16'h0000;
    endtask

    task automatic check_reset_outputs(input string name);
        tests_run++;
        if (anode_n !== 4'b1111) begin
            tests_failed++;
            $display("FAIL %s anode_n: got %b expected 1111", name, anode_n);
        end
        tests_run++;
        if (digit_data !== 4'h0) begin
            tests_failed++;
            $display("FAIL %s digit_data: got %h expected 0", name, digit_data);
        end
        tests_run++;
        if (digit_idx !== 2'd0) begin
            tests_failed++;
            $display("FAIL %s digit_idx: got %0d expected 0", name, digit_idx);
        end
        tests_run++;
        if (frame_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s frame_tick: got %b expected 0", name, frame_tick);
        end
        tests_run++;
        if (load_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s load_ready: got %b expected 1", name, load_ready);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_value = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        model_reset();
        run_frame("reset_frame0", -1, 16'h0, -1, 16'h0);
        run_frame("reset_frame1", -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_load_commit();
        run_frame("load_1234", 8, 16'h1234, 14, 16'hBEEF);
        run_frame("show_1234", -1, 16'h0, -1, 16'h0);
        run_frame("still_1234", -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_back_to_back();
        run_frame("load_abcd_on_tick", FRAME - 1, 16'hABCD, -1, 16'h0);
        run_frame("abcd_waits", -1, 16'h0, -1, 16'h0);
        run_frame("abcd_shown", -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_leading_zero();
        run_frame("load_0050", 3, 16'h0050, -1, 16'h0);
        run_frame("show_0050", -1, 16'h0, -1, 16'h0);
        run_frame("load_0000", 0, 16'h0000, -1, 16'h0);
        run_frame("show_0000", -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_reset_mid();
        load_valid = 1'b0;
        for (int p = 0; p < 15; p++) begin
            load_valid = (p == 5);
            load_value = (p == 5) ? 16'h5555 : 16'h0000;
            @(negedge clk);
        end
        load_valid = 1'b0;
        tests_run++;
        if (anode_n !== 4'b1011 || load_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: anode_n=%b load_ready=%b expected 1011/0", anode_n, load_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid");
        rst_n = 1'b1;
        model_reset();
        run_frame("after_reset_mid", -1, 16'h0, -1, 16'h0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        load_valid   = 1'b0;
        load_value   = 16'h0000;
        model_reset();
        test_reset();
        test_load_commit();
        test_back_to_back();
        test_leading_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIV, default 50000, ON-time per digit in clock cycles (>=1).
REQ-002 SHALL have parameter BLANK, default 16, all-anodes-off guard time before each digit in cycles (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port load_valid  input  1  new 16-bit display value offered.
REQ-006 SHALL have port load_value  input  16  four hex digits; [3:0] is digit 0 (rightmost).
REQ-007 SHALL have port load_ready  output  1  shadow register free; a load is accepted on load_valid&&load_ready.
REQ-008 SHALL have port digit_data  output  4  nibble of the current digit, drives the downstream hex-to-7-segment decoder.
REQ-009 SHALL have port digit_idx  output  2  index of the digit currently scanned.
REQ-010 SHALL have port anode_n  output  4  active-low digit enables, one-hot-low or all high.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse at end of each full 4-digit frame.

Function
REQ-012 SHALL hold registers: disp (16 bits, shown), shadow (16 bits), pending (1 bit), state {S_BLANK, S_ON}, cycle counter, digit_idx.
REQ-013 SHALL, in S_BLANK, drive anode_n=4'b1111 for exactly BLANK cycles, then enter S_ON with the counter cleared.
REQ-014 SHALL, in S_ON, drive anode_n low only at bit digit_idx for exactly DIV cycles, then enter S_BLANK with digit_idx incremented modulo 4 (3 wraps to 0).
REQ-015 SHALL make one digit slot BLANK+DIV cycles and one frame 4*(BLANK+DIV) cycles.
REQ-016 SHALL drive digit_data = disp[4*digit_idx+3 : 4*digit_idx], registered, and update it on the same edge as digit_idx.
REQ-017 SHALL assert frame_tick for one cycle on the cycle where the S_ON to S_BLANK transition leaves digit 3.
REQ-018 SHALL drive load_ready = !pending; on an accepted load, capture load_value into shadow and set pending on the next edge.
REQ-019 SHALL, on the frame_tick cycle with pending=1, copy shadow to disp and clear pending, so that the new value first appears on digit 0 of the next frame (no tearing within a frame).
REQ-020 SHALL, when a load is accepted in the frame_tick cycle itself, not commit it in that cycle; it commits at the following frame end.
REQ-021 SHALL ignore load_valid while load_ready=0; the offered value is not captured.
REQ-022 SHALL ensure anode_n never has more than one bit low in any cycle.

Reset
REQ-023 SHALL, on any edge with rst_n=0, including mid-slot, set disp=0, shadow=0, pending=0, state=S_BLANK, counter=0, digit_idx=0.
REQ-024 SHALL, during reset, drive the outputs to anode_n=4'b1111, digit_data=4'h0, frame_tick=0, load_ready=1.
REQ-025 SHALL start the first BLANK period on the first edge after rst_n returns high.

Configuration
REQ-026 SHALL use macro SEG_LEADING_ZERO_BLANK_EN to select leading-zero blanking.
REQ-027 SHALL, with SEG_LEADING_ZERO_BLANK_EN defined, keep anode_n all high during S_ON of any digit k>0 whose nibble and all higher nibbles of disp are zero; digit 0 is always lit, and slot timing is unchanged.
REQ-028 SHALL, without SEG_LEADING_ZERO_BLANK_EN, light all four digits in every frame.

Verification (DIV=4, BLANK=2; frame = 24 cycles)
REQ-029 Scenario: reset release -> anode_n=1111 for 2 cycles, then 1110 for 4, 1111 for 2, 1101 for 4, and so on; frame_tick high on cycle 24 only.
REQ-030 Scenario: load 16'h1234 mid-frame -> load_ready low the next cycle; digit_data stays 0 until the frame ends; the next frame shows 4,3,2,1 on idx 0..3; load_ready high after the commit.
REQ-031 Scenario: second load_valid (16'hBEEF) while pending -> not captured; disp becomes the first value only.
REQ-032 Scenario: load 16'hABCD exactly on the frame_tick cycle -> committed one frame later (24 cycles), not immediately.
REQ-033 Scenario: rst_n low for one cycle during the digit 2 ON slot -> next cycle anode_n=1111, digit_idx=0, disp=0, load_ready=1.
REQ-034 Scenario: with SEG_LEADING_ZERO_BLANK_EN, disp=16'h0050 -> digits 0 and 1 lit; anode_n stays 1111 through the idx 2 and idx 3 ON slots. Without the macro, all four digits are lit.
